// File: rtl/cpu_ram_responder_pkg.sv
// Shared definitions for the SimpleCPU RAM responder: FSM state encoding and bus data width.
package cpu_ram_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HRESP = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_ram_responder_if.sv
// Bus bundle between the CPU / host loader (master) and the RAM responder (slave).
interface cpu_ram_responder_if #(parameter int SIZE = 10);
  import cpu_ram_responder_pkg::*;

  logic              wrEn;
  logic [SIZE-1:0]   addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic [DATA_W-1:0] data_fromRAM;

  logic              host_hold;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [SIZE-1:0]   host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic              host_rready;
  logic [DATA_W-1:0] host_rdata;

  logic              clear_start;
  logic              busy;

  modport master (
    output wrEn, addr_toRAM, data_toRAM,
    output host_hold, host_valid, host_we, host_addr, host_wdata, host_rready,
    output clear_start,
    input  data_fromRAM, host_ready, host_rvalid, host_rdata, busy
  );

  modport slave (
    input  wrEn, addr_toRAM, data_toRAM,
    input  host_hold, host_valid, host_we, host_addr, host_wdata, host_rready,
    input  clear_start,
    output data_fromRAM, host_ready, host_rvalid, host_rdata, busy
  );

endinterface

// File: rtl/cpu_ram_responder_ram_array_1p.sv
// Single-port word array: synchronous write, read word presented for the caller to register at
// the same edge, so a same-address write returns the old word (read-first).
module ram_array_1p
  import cpu_ram_responder_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SIZE-1:0]   addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cpu_ram_responder.sv
// RAM responder for the SimpleCPU bus: 1-cycle CPU reads, host load/dump handshake while the
// CPU is held, and a hardware sweep that zeroes the whole array.
module cpu_ram_responder
  import cpu_ram_responder_pkg::*;
#(
  parameter int SIZE = 10
) (
  input logic                clk,
  input logic                rst,
  cpu_ram_responder_if.slave bus
);

  state_t            state;
  logic [SIZE-1:0]   counter;
  logic [DATA_W-1:0] cpu_rdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              host_ready;
  logic              host_fire;
  logic              cpu_active;
  logic              mem_we;
  logic [SIZE-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // rst gates ready because state already reads IDLE while reset is held
  assign host_ready = rst && (state == ST_IDLE) && bus.host_hold && !bus.clear_start;
  assign host_fire  = host_ready && bus.host_valid;
  assign cpu_active = (state == ST_IDLE) && !bus.host_hold && !bus.clear_start;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.addr_toRAM;
    mem_wdata = bus.data_toRAM;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = counter;
      mem_wdata = '0;
    end else if (host_fire) begin
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end else if (cpu_active) begin
      mem_we    = bus.wrEn;
    end
  end

  ram_array_1p #(.SIZE(SIZE)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      counter   <= '0;
      cpu_rdata <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear_start) begin
            state   <= ST_CLEAR;
            counter <= '0;
            busy    <= 1'b1;
          end else if (host_fire) begin
            if (!bus.host_we) begin
              rdata  <= mem_rdata;
              rvalid <= 1'b1;
              state  <= ST_HRESP;
            end
          end else if (cpu_active) begin
            cpu_rdata <= mem_rdata;
          end
        end
        ST_CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == '1) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_HRESP: begin
          if (bus.host_rready) begin
            rvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_fromRAM = cpu_rdata;
  assign bus.host_ready   = host_ready;
  assign bus.host_rvalid  = rvalid;
  assign bus.host_rdata   = rdata;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Self-checking bench for cpu_ram_responder (SIZE=4): vector tables, directed corner sequences
// and a randomized run against a word-array reference model.
module tb_cpu_ram_responder;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0]     model_mem [DEPTH];
  logic [31:0]     model_cpu_out;
  logic [31:0]     model_rdata;
  logic            pending;

  typedef struct {
    logic hold;
    logic clr;
    logic valid;
    logic exp_ready;
  } ready_vec_t;

  typedef struct {
    logic            wr;
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
    logic [31:0]     exp;
  } cpu_vec_t;

  ready_vec_t ready_tab [5];
  cpu_vec_t   cpu_tab [5];

  cpu_ram_responder_if #(.SIZE(SIZE)) bus ();

  cpu_ram_responder #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic hold, input logic wr, input logic [SIZE-1:0] addr,
                                input logic [31:0] data);
    bus.host_hold  = hold;
    bus.wrEn       = wr;
    bus.addr_toRAM = addr;
    bus.data_toRAM = data;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.host_ready && n < 64) begin
      step();
      n++;
    end
    check_output(name, {31'd0, bus.host_ready}, 32'd1);
  endtask

  task automatic host_write(input logic [SIZE-1:0] addr, input logic [31:0] data);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    wait_ready("host_write_ready");
    step();
    bus.host_valid = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic host_read(input logic [SIZE-1:0] addr, input string name);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = addr;
    wait_ready("host_read_ready");
    step();
    bus.host_valid = 1'b0;
    check_output({name, "_rvalid"}, {31'd0, bus.host_rvalid}, 32'd1);
    check_output({name, "_rdata"}, bus.host_rdata, model_mem[addr]);
    bus.host_rready = 1'b1;
    step();
    bus.host_rready = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    bus.host_valid  = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.host_rready = 1'b0;
    bus.clear_start = 1'b0;

    // Reset values, including ready held low even though hold is asserted
    #2;
    check_output("rst_data_fromRAM", bus.data_fromRAM, 32'd0);
    check_output("rst_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    check_output("rst_rdata", bus.host_rdata, 32'd0);
    check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_output("rst_ready", {31'd0, bus.host_ready}, 32'd0);
    #10 rst = 1'b1;
    step();

    ready_tab[0] = '{1'b0, 1'b0, 1'b1, 1'b0};
    ready_tab[1] = '{1'b1, 1'b0, 1'b1, 1'b1};
    ready_tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
    ready_tab[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
    ready_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bus.host_hold   = ready_tab[i].hold;
      bus.clear_start = ready_tab[i].clr;
      bus.host_valid  = ready_tab[i].valid;
      bus.host_we     = 1'b1;
      #1;
      check_output($sformatf("ready_vec%0d", i), {31'd0, bus.host_ready}, {31'd0, ready_tab[i].exp_ready});
      bus.clear_start = 1'b0;
      bus.host_valid  = 1'b0;
      bus.host_hold   = 1'b1;
      step();
    end

    for (int i = 0; i < DEPTH; i++) host_write(SIZE'(i), 32'h100 + i);

    // Host read held across several cycles until rready
    host_write(4'd3, 32'hDEADBEEF);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 4'd3;
    #1;
    check_output("t1_ready", {31'd0, bus.host_ready}, 32'd1);
    step();
    bus.host_valid = 1'b0;
    check_output("t1_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
    check_output("t1_rdata", bus.host_rdata, 32'hDEADBEEF);
    check_output("t1_ready_hresp", {31'd0, bus.host_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("t1_rvalid_held", {31'd0, bus.host_rvalid}, 32'd1);
      check_output("t1_rdata_held", bus.host_rdata, 32'hDEADBEEF);
    end
    bus.host_rready = 1'b1;
    step();
    bus.host_rready = 1'b0;
    check_output("t1_rvalid_drop", {31'd0, bus.host_rvalid}, 32'd0);
    check_output("t1_ready_back", {31'd0, bus.host_ready}, 32'd1);

    // CPU port: read-first, 1-cycle latency
    cpu_tab[0] = '{1'b1, 4'd5, 32'h12, 32'h105};
    cpu_tab[1] = '{1'b0, 4'd5, 32'h0, 32'h12};
    cpu_tab[2] = '{1'b1, 4'd3, 32'h77, 32'hDEADBEEF};
    cpu_tab[3] = '{1'b0, 4'd3, 32'h0, 32'h77};
    cpu_tab[4] = '{1'b0, 4'd0, 32'h0, 32'h100};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, cpu_tab[i].wr, cpu_tab[i].addr, cpu_tab[i].data);
      step();
      check_output($sformatf("cpu_vec%0d", i), bus.data_fromRAM, cpu_tab[i].exp);
      if (cpu_tab[i].wr) model_mem[cpu_tab[i].addr] = cpu_tab[i].data;
    end
    model_cpu_out = 32'h100;

    // CPU write while host holds the array is dropped
    apply_stimulus(1'b1, 1'b1, 4'd6, 32'hBAD);
    step();
    check_output("t5_hold_cpu_out", bus.data_fromRAM, model_cpu_out);
    apply_stimulus(1'b1, 1'b0, 4'd6, 32'h0);
    host_read(4'd6, "t5_hold_word6");

    pending = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic            hold, valid, we, rready, wr;
      logic [SIZE-1:0] haddr, caddr;
      logic [31:0]     hdata, cdata;
      hold   = ($urandom_range(0, 2) != 0);
      valid  = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      wr     = 1'($urandom_range(0, 1));
      haddr  = SIZE'($urandom_range(0, DEPTH - 1));
      caddr  = SIZE'($urandom_range(0, DEPTH - 1));
      hdata  = $urandom;
      cdata  = $urandom;
      apply_stimulus(hold, wr, caddr, cdata);
      bus.host_valid  = valid;
      bus.host_we     = we;
      bus.host_addr   = haddr;
      bus.host_wdata  = hdata;
      bus.host_rready = rready;
      #1;
      check_output("rand_ready", {31'd0, bus.host_ready}, {31'd0, !pending && hold});
      if (pending) begin
        if (rready) pending = 1'b0;
      end else if (hold && valid) begin
        if (we) model_mem[haddr] = hdata;
        else begin
          model_rdata = model_mem[haddr];
          pending     = 1'b1;
        end
      end else if (!hold) begin
        model_cpu_out = model_mem[caddr];
        if (wr) model_mem[caddr] = cdata;
      end
      step();
      check_output("rand_cpu_out", bus.data_fromRAM, model_cpu_out);
      check_output("rand_rvalid", {31'd0, bus.host_rvalid}, {31'd0, pending});
      if (pending) check_output("rand_rdata", bus.host_rdata, model_rdata);
    end
    apply_stimulus(1'b1, 1'b0, '0, '0);
    bus.host_valid  = 1'b0;
    bus.host_rready = 1'b1;
    step();
    bus.host_rready = 1'b0;

    // Clear sweep racing a host write; re-trigger and CPU writes mid-sweep are ignored
    for (int i = 0; i < DEPTH; i++) host_write(SIZE'(i), 32'hFF);
    bus.clear_start = 1'b1;
    bus.host_valid  = 1'b1;
    bus.host_we     = 1'b1;
    bus.host_addr   = 4'd9;
    bus.host_wdata  = 32'h5A5A;
    #1;
    check_output("t4_ready_vs_clear", {31'd0, bus.host_ready}, 32'd0);
    step();
    bus.clear_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (i == 4) bus.clear_start = 1'b1;
      if (i == 5) bus.clear_start = 1'b0;
      if (i == 8) apply_stimulus(1'b0, 1'b1, 4'd2, 32'hBAD);
      if (i == 11) apply_stimulus(1'b1, 1'b0, 4'd2, 32'h0);
      step();
    end
    check_output("t3_busy_cycles", busy_cnt, 32'd16);
    check_output("t4_ready_after_clear", {31'd0, bus.host_ready}, 32'd1);
    step();
    bus.host_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_mem[9] = 32'h5A5A;
    for (int i = 0; i < DEPTH; i++) host_read(SIZE'(i), $sformatf("t3_word%0d", i));

    // Reset during the sweep leaves a partially cleared array
    for (int i = 0; i < DEPTH; i++) host_write(SIZE'(i), 32'hFF);
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    #1;
    check_output("t6_busy_reset", {31'd0, bus.busy}, 32'd0);
    check_output("t6_ready_reset", {31'd0, bus.host_ready}, 32'd0);
    check_output("t6_cpu_out_reset", bus.data_fromRAM, 32'd0);
    #2 rst = 1'b1;
    step();
    for (int i = 0; i < 7; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < DEPTH; i++) host_read(SIZE'(i), $sformatf("t6_word%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
